shift_arb: RTL and testbench
============================

SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as the codebase names them (clk, rst), listed first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req0_valid  input  1  requester 0 has a shift operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_data  input  16  requester 0 operand.
REQ-007 req0_amt  input  4  requester 0 shift amount, 0..15.
REQ-008 req0_op  input  2  requester 0 opcode: 00 rotate-left, 01 logical-left, 10 rotate-right, 11 logical-right.
REQ-009 req1_valid, req1_ready, req1_data, req1_amt, req1_op SHALL mirror REQ-004..REQ-008 for requester 1.
REQ-010 rsp_valid  output  1  result register holds a valid result.
REQ-011 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-012 rsp_data  output  16  shifted result.
REQ-013 rsp_id  output  1  requester index that owns rsp_data.
REQ-014 grant_cnt0, grant_cnt1  output  8  per-requester accepted-operation counters.

Function
REQ-015 Accept condition: reqN_valid & reqN_ready; at most one requester SHALL be ready in any cycle.
REQ-016 Result register states: EMPTY, FULL; capacity one entry.
REQ-017 can_accept = EMPTY, or FULL with rsp_ready high (same-cycle drain and refill).
REQ-018 reqN_ready SHALL be high only when can_accept is high and N holds the grant.
REQ-019 Grant, only one valid: that requester.
REQ-020 Grant, both valid: requester opposite to last_grant (round-robin); last_grant SHALL update only on an accepted operation.
REQ-021 Grant logic SHALL depend on reqN_valid but reqN_ready SHALL NOT depend on reqN_data/amt/op.
REQ-022 Latency: operation accepted in cycle N SHALL appear as rsp_valid=1, rsp_data, rsp_id in cycle N+1.
REQ-023 rsp_data SHALL equal the 16-bit shift of the operand per op and amt; amt=0 SHALL pass the operand unchanged; logical shifts zero-fill.
REQ-024 While FULL and rsp_ready low, rsp_data, rsp_id and rsp_valid SHALL hold stable.
REQ-025 FULL with rsp_ready high and no accept: transition to EMPTY, rsp_valid low next cycle.
REQ-026 grant_cntN SHALL increment on each requester-N accept and saturate at 255.
REQ-027 A requester dropping valid without acceptance SHALL NOT change last_grant or counters.

Reset
REQ-028 On rst: state EMPTY, rsp_valid=0, rsp_data=16'h0000, rsp_id=0, last_grant=1 (requester 0 wins first tie), grant_cnt0=grant_cnt1=0.
REQ-029 rst mid-operation SHALL discard any held result; reqN_ready SHALL be 0 during the rst cycle.

Configuration
REQ-030 Macro SHIFT_ARB_FIXED_PRIO_EN: defined -> requester 0 SHALL always win ties and last_grant is unused; undefined -> round-robin per REQ-020.

Structure
REQ-031 Shared package SHALL hold the opcode constants (ROL, SLL, ROR, SRL) and the EMPTY/FULL state encoding.
REQ-032 The datapath SHALL be the existing combinational shifter module instantiated as a single sub-module (shifter) fed by the granted requester's mux output.

Verification
REQ-033 req0 only: data=16'h8001, amt=1, op=00 -> next cycle rsp_valid=1, rsp_data=16'h0003, rsp_id=0, grant_cnt0=1.
REQ-034 Both valid for 4 cycles, rsp_ready=1, req0 op=11 amt=4 data=16'h00F0, req1 op=10 amt=8 data=16'h1234 -> rsp_id sequence 0,1,0,1; data 16'h000F / 16'h3412 (fixed-prio build: all 0).
REQ-035 FULL with rsp_ready=0 for 3 cycles, req1 valid -> req1_ready=0, rsp_data stable; rsp_ready=1 -> same-cycle accept, new result next cycle.
REQ-036 op=01, amt=0, data=16'hA5A5 -> rsp_data=16'hA5A5; amt=15, data=16'hFFFF -> 16'h8000.
REQ-037 rst asserted while FULL -> next cycle rsp_valid=0, counters 0, first subsequent tie granted to requester 0.
REQ-038 300 back-to-back req0 accepts -> grant_cnt0 saturates at 255.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// Shared definitions for the shift_arb block: opcode constants for the
// shifter datapath, the result-register state encoding, and widths.
package shift_arb_pkg;

  localparam int DATA_W = 16;
  localparam int AMT_W  = 4;
  localparam int CNT_W  = 8;

  // Shift opcodes
  localparam logic [1:0] ROL = 2'b00;  // rotate left
  localparam logic [1:0] SLL = 2'b01;  // logical left, zero fill
  localparam logic [1:0] ROR = 2'b10;  // rotate right
  localparam logic [1:0] SRL = 2'b11;  // logical right, zero fill

  // Result register occupancy (capacity one entry)
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/shift_arb_shifter.sv
// Combinational 16-bit shifter.
// Ports:
//   data   - operand
//   amt    - shift amount 0..15 (0 passes the operand unchanged)
//   op     - ROL / SLL / ROR / SRL
//   result - shifted operand
module shift_arb_shifter
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] result
);

  // Complementary shift distance for the rotates; at amt=0 it is 16, which
  // shifts the 16-bit operand out completely and leaves only the pass-through.
  logic [AMT_W:0] inv_amt;

  always_comb begin
    inv_amt = 5'(DATA_W) - {1'b0, amt};
    unique case (op)
      ROL:     result = (data << amt) | (data >> inv_amt);
      SLL:     result = data << amt;
      ROR:     result = (data >> amt) | (data << inv_amt);
      default: result = data >> amt;
    endcase
  end

endmodule

// File: rtl/shift_arb.sv
// Two-requester arbiter in front of a shared shifter with a one-entry
// result register.
//
// Handshake: a transfer happens on any rising edge where valid and ready
// are both high. reqN_ready never depends on reqN_data/amt/op; rsp_valid,
// rsp_data and rsp_id hold stable while rsp_valid is high and rsp_ready
// is low.
//
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   reqN_valid/ready           - requester N handshake (N = 0, 1)
//   reqN_data/amt/op           - requester N operand, shift amount, opcode
//   rsp_valid/ready            - result handshake
//   rsp_data, rsp_id           - shifted result and owning requester
//   grant_cnt0, grant_cnt1     - saturating accepted-operation counters
//   dbg_state                  - result register state (EMPTY/FULL)
//
// Configuration: define SHIFT_ARB_FIXED_PRIO_EN to make requester 0 win
// every tie; otherwise ties alternate round-robin.
module shift_arb
  import shift_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  input  logic [1:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output rsp_state_e        dbg_state
);

  rsp_state_e        state, state_next;
  logic              gnt1;
  logic              can_accept;
  logic              accept0, accept1, accept;
  logic [DATA_W-1:0] mux_data;
  logic [AMT_W-1:0]  mux_amt;
  logic [1:0]        mux_op;
  logic [DATA_W-1:0] shift_result;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
  logic last_grant;  // requester that won the most recent accept
`endif

  // Grant: requester 1 wins when alone, or on a tie when requester 0 went last.
  always_comb begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    gnt1 = req1_valid & ~req0_valid;
`else
    gnt1 = req1_valid & (~req0_valid | ~last_grant);
`endif
  end

  // Same-cycle drain and refill is allowed when the consumer takes the result.
  assign can_accept = (state == EMPTY) | rsp_ready;
  assign req0_ready = ~rst & can_accept & req0_valid & ~gnt1;
  assign req1_ready = ~rst & can_accept & gnt1;
  assign accept0    = req0_valid & req0_ready;
  assign accept1    = req1_valid & req1_ready;
  assign accept     = accept0 | accept1;

  assign mux_data = gnt1 ? req1_data : req0_data;
  assign mux_amt  = gnt1 ? req1_amt  : req0_amt;
  assign mux_op   = gnt1 ? req1_op   : req0_op;

  shift_arb_shifter shifter (
    .data   (mux_data),
    .amt    (mux_amt),
    .op     (mux_op),
    .result (shift_result)
  );

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = FULL;
    end else if (state == FULL && rsp_ready) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      rsp_data <= shift_result;
      rsp_id   <= accept1;
      if (accept0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (accept1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end

`ifndef SHIFT_ARB_FIXED_PRIO_EN
  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= accept1;
    end
  end
`endif

  assign rsp_valid = (state == FULL);
  assign dbg_state = state;

endmodule

// File: tb/tb_shift_arb.sv
module tb_shift_arb;
  import shift_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0]       req0_data, req1_data;
  logic [3:0]        req0_amt, req1_amt;
  logic [1:0]        req0_op, req1_op;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [15:0]       rsp_data;
  logic [7:0]        grant_cnt0, grant_cnt1;
  rsp_state_e        dbg_state;

  shift_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit        m_full;
  bit [15:0] m_data;
  bit        m_id;
  bit        m_last;   // winner of the previous accept
  int        m_cnt0, m_cnt1;
  logic [15:0] exp_q[$];  // results in flight (at most one)

  function automatic logic [15:0] ref_shift(logic [15:0] d, int amt, logic [1:0] op);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < amt; i++) begin
      case (op)
        2'b00:   r = {r[14:0], r[15]};
        2'b01:   r = {r[14:0], 1'b0};
        2'b10:   r = {r[0], r[15:1]};
        default: r = {1'b0, r[15:1]};
      endcase
    end
    return r;
  endfunction

  task automatic model_ready(output bit e0, output bit e1);
    bit can;
    int w;
    can = !m_full || rsp_ready;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    w = 0;
`else
    w = m_last ? 0 : 1;
`endif
    e0 = !rst && can && req0_valid && (!req1_valid || w == 0);
    e1 = !rst && can && req1_valid && (!req0_valid || w == 1);
  endtask

  // One clock: check handshake before the edge, advance model, check outputs.
  task automatic step(output logic s_r0, output logic s_r1);
    bit e0, e1;
    logic [15:0] res;
    #1;
    model_ready(e0, e1);
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    chk("req0_ready", 16'(req0_ready), 16'(e0));
    chk("req1_ready", 16'(req1_ready), 16'(e1));
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_id = 0; m_last = 1; m_cnt0 = 0; m_cnt1 = 0;
      exp_q.delete();
    end else if (e0 || e1) begin
      if (e1) res = ref_shift(req1_data, int'(req1_amt), req1_op);
      else    res = ref_shift(req0_data, int'(req0_amt), req0_op);
      exp_q.delete();
      exp_q.push_back(res);
      m_full = 1; m_id = e1; m_last = e1;
      if (e0 && m_cnt0 < 255) m_cnt0++;
      if (e1 && m_cnt1 < 255) m_cnt1++;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
      exp_q.delete();
    end
    #1;
    chk("rsp_valid", 16'(rsp_valid), 16'(m_full));
    chk("dbg_state", 16'(dbg_state), m_full ? 16'(FULL) : 16'(EMPTY));
    if (m_full && exp_q.size() == 1) begin
      chk("rsp_data", rsp_data, exp_q[0]);
      chk("rsp_id", 16'(rsp_id), 16'(m_id));
    end
    chk("grant_cnt0", 16'(grant_cnt0), 16'(m_cnt0));
    chk("grant_cnt1", 16'(grant_cnt1), 16'(m_cnt1));
  endtask

  task automatic drive(input bit v0, input logic [15:0] d0, input logic [3:0] a0, input logic [1:0] o0,
                       input bit v1, input logic [15:0] d1, input logic [3:0] a1, input logic [1:0] o1,
                       input bit rr);
    req0_valid = v0; req0_data = d0; req0_amt = a0; req0_op = o0;
    req1_valid = v1; req1_data = d1; req1_amt = a1; req1_op = o1;
    rsp_ready = rr;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit v0; logic [15:0] d0; logic [3:0] a0; logic [1:0] o0;
    bit v1; logic [15:0] d1; logic [3:0] a1; logic [1:0] o1;
    bit rr;
    bit e_r0; bit e_r1; bit e_valid; logic [15:0] e_data; bit e_id;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic r0, r1;
    logic [15:0] held;

    // Ties: 0,1,0,1 round-robin (all 0 with fixed priority)
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    tbl[0] = '{1, 16'h00F0, 4, 2'b11, 1, 16'h1234, 8, 2'b10, 1, 1, 0, 1, 16'h000F, 0};
    tbl[1] = '{1, 16'h00F0, 4, 2'b11, 1, 16'h1234, 8, 2'b10, 1, 1, 0, 1, 16'h000F, 0};
    tbl[2] = '{1, 16'h00F0, 4, 2'b11, 1, 16'h1234, 8, 2'b10, 1, 1, 0, 1, 16'h000F, 0};
    tbl[3] = '{1, 16'h00F0, 4, 2'b11, 1, 16'h1234, 8, 2'b10, 1, 1, 0, 1, 16'h000F, 0};
`else
    tbl[0] = '{1, 16'h00F0, 4, 2'b11, 1, 16'h1234, 8, 2'b10, 1, 1, 0, 1, 16'h000F, 0};
    tbl[1] = '{1, 16'h00F0, 4, 2'b11, 1, 16'h1234, 8, 2'b10, 1, 0, 1, 1, 16'h3412, 1};
    tbl[2] = '{1, 16'h00F0, 4, 2'b11, 1, 16'h1234, 8, 2'b10, 1, 1, 0, 1, 16'h000F, 0};
    tbl[3] = '{1, 16'h00F0, 4, 2'b11, 1, 16'h1234, 8, 2'b10, 1, 0, 1, 1, 16'h3412, 1};
`endif
    tbl[4]  = '{1, 16'hA5A5, 0,  2'b01, 0, 16'h0, 0,  2'b00, 1, 1, 0, 1, 16'hA5A5, 0};
    tbl[5]  = '{1, 16'hFFFF, 15, 2'b01, 0, 16'h0, 0,  2'b00, 1, 1, 0, 1, 16'h8000, 0};
    tbl[6]  = '{1, 16'h8001, 1,  2'b00, 0, 16'h0, 0,  2'b00, 1, 1, 0, 1, 16'h0003, 0};
    tbl[7]  = '{0, 16'h0,    0,  2'b00, 0, 16'h0, 0,  2'b00, 1, 0, 0, 0, 16'h0000, 0};
    tbl[8]  = '{0, 16'h0,    0,  2'b00, 1, 16'h8000, 15, 2'b11, 1, 0, 1, 1, 16'h0001, 1};
    tbl[9]  = '{0, 16'h0,    0,  2'b00, 0, 16'h0, 0,  2'b00, 0, 0, 0, 1, 16'h0001, 1};
    tbl[10] = '{1, 16'h5555, 3,  2'b00, 0, 16'h0, 0,  2'b00, 0, 0, 0, 1, 16'h0001, 1};
    tbl[11] = '{0, 16'h0,    0,  2'b00, 0, 16'h0, 0,  2'b00, 1, 0, 0, 0, 16'h0000, 0};

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(r0, r1);
    step(r0, r1);
    chk("reset rsp_data", rsp_data, 16'h0000);
    chk("reset rsp_id", 16'(rsp_id), 16'h0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v0, tbl[i].d0, tbl[i].a0, tbl[i].o0,
            tbl[i].v1, tbl[i].d1, tbl[i].a1, tbl[i].o1, tbl[i].rr);
      step(r0, r1);
      chk("tbl req0_ready", 16'(r0), 16'(tbl[i].e_r0));
      chk("tbl req1_ready", 16'(r1), 16'(tbl[i].e_r1));
      chk("tbl rsp_valid", 16'(rsp_valid), 16'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk("tbl rsp_data", rsp_data, tbl[i].e_data);
        chk("tbl rsp_id", 16'(rsp_id), 16'(tbl[i].e_id));
      end
    end

    // FULL with rsp_ready low for 3 cycles: req1 stalled, result held
    drive(1, 16'h0F0F, 4, 2'b00, 0, 0, 0, 0, 1);
    step(r0, r1);
    held = rsp_data;
    chk("fill data", rsp_data, 16'hF0F0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 16'h00FF, 8, 2'b01, 0);
      step(r0, r1);
      chk("stall req1_ready", 16'(r1), 16'h0);
      chk("stall rsp_data", rsp_data, held);
      chk("stall rsp_valid", 16'(rsp_valid), 16'h1);
    end
    drive(0, 0, 0, 0, 1, 16'h00FF, 8, 2'b01, 1);
    step(r0, r1);
    chk("drain req1_ready", 16'(r1), 16'h1);
    chk("refill rsp_data", rsp_data, 16'hFF00);
    chk("refill rsp_id", 16'(rsp_id), 16'h1);

    // Reset while FULL, then first tie goes to requester 0
    drive(1, 16'h1111, 1, 2'b00, 0, 0, 0, 0, 0);
    step(r0, r1);
    rst = 1'b1;
    drive(1, 16'h2222, 1, 2'b00, 1, 16'h3333, 1, 2'b00, 1);
    step(r0, r1);
    chk("rst req0_ready", 16'(r0), 16'h0);
    chk("rst req1_ready", 16'(r1), 16'h0);
    chk("post-rst rsp_valid", 16'(rsp_valid), 16'h0);
    chk("post-rst cnt0", 16'(grant_cnt0), 16'h0);
    rst = 1'b0;
    step(r0, r1);
    chk("post-rst tie id", 16'(rsp_id), 16'h0);
    chk("post-rst tie data", rsp_data, 16'h4444);

    // 300 back-to-back requester-0 accepts saturate the counter
    for (int i = 0; i < 300; i++) begin
      drive(1, 16'($urandom), 4'($urandom), 2'($urandom), 0, 0, 0, 0, 1);
      step(r0, r1);
    end
    chk("cnt0 saturated", 16'(grant_cnt0), 16'd255);

    // Randomized traffic against the model, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 1), 16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 1), 16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0);
      step(r0, r1);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
